// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per cycle.
// Optional macro SERIAL_SUB_BACK_TO_BACK_EN lets DONE accept new operands on the consuming edge.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             of
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic              idle_rdy;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  acc;
    logic              br;
    logic [CW-1:0]     cnt;
    logic              a_msb;
    logic              b_msb;

    logic [DIGIT-1:0]       d_digit;
    logic                   br_next;
    logic [WIDTH+DIGIT-1:0] acc_wide;
    logic [WIDTH-1:0]       acc_next;
    logic                   of_next;
    logic                   last_step;

    // Ripple-borrow chain over the current low digit of the operand registers
    always_comb begin
        logic x;
        logic y;
        logic c;
        d_digit = '0;
        c       = br;
        x       = 1'b0;
        y       = 1'b0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            x          = a_sh[i];
            y          = b_sh[i];
            d_digit[i] = x ^ y ^ c;
            c          = (~x & y) | (~(x ^ y) & c);
        end
        br_next  = c;
        acc_wide = {d_digit, acc};
        acc_next = acc_wide[WIDTH+DIGIT-1:DIGIT];
        of_next  = (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
    end

    assign last_step = (cnt == CW'(STEPS - 1));

`ifdef SERIAL_SUB_BACK_TO_BACK_EN
    // In DONE readiness follows the consumer so a result and new operands can swap on one edge
    assign in_ready = (state == DONE) ? out_ready : idle_rdy;
`else
    assign in_ready = idle_rdy;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idle_rdy  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            of        <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        br       <= bin;
                        cnt      <= '0;
                        idle_rdy <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    acc  <= acc_next;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (last_step) begin
                        diff      <= acc_next;
                        bout      <= br_next;
                        of        <= of_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef SERIAL_SUB_BACK_TO_BACK_EN
                        if (start) begin
                            a_sh  <= a;
                            b_sh  <= b;
                            a_msb <= a[WIDTH-1];
                            b_msb <= b[WIDTH-1];
                            br    <= bin;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            idle_rdy <= 1'b1;
                            state    <= IDLE;
                        end
`else
                        idle_rdy <= 1'b1;
                        state    <= IDLE;
`endif
                    end
                end
                default: begin
                    idle_rdy <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: DIGIT=1 and DIGIT=8 instances share stimulus, checked against plain arithmetic.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_ready;

    logic        in_ready1, out_valid1, bout1, of1;
    logic [31:0] diff1;
    logic        in_ready8, out_valid8, bout8, of8;
    logic [31:0] diff8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready1),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid1), .out_ready(out_ready),
        .diff(diff1), .bout(bout1), .of(of1)
    );

    serial_subtractor #(.WIDTH(32), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .in_ready(in_ready8),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid8), .out_ready(out_ready),
        .diff(diff8), .bout(bout8), .of(of8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [31:0] ra, input logic [31:0] rb, input logic rbin,
                             output logic [31:0] rd, output logic rbo, output logic rof);
        logic [32:0] full;
        full = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
        rd   = full[31:0];
        rbo  = ({1'b0, ra} < ({1'b0, rb} + 33'(rbin)));
        rof  = (ra[31] != rb[31]) && (rd[31] != ra[31]);
    endtask

    task automatic launch(input logic [31:0] la, input logic [31:0] lb, input logic lbin);
        chk("ready1_before_start", 64'(in_ready1), 64'd1);
        chk("ready8_before_start", 64'(in_ready8), 64'd1);
        a     = la;
        b     = lb;
        bin   = lbin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ready1_after_accept", 64'(in_ready1), 64'd0);
    endtask

    task automatic await_result(input string tag, input logic [31:0] la, input logic [31:0] lb,
                                input logic lbin);
        int          l1;
        int          l8;
        logic [31:0] ed;
        logic        ebo;
        logic        eof;
        l1 = -1;
        l8 = -1;
        for (int k = 1; k <= 40 && (l1 < 0 || l8 < 0); k++) begin
            @(posedge clk);
            #1;
            if (l1 < 0 && out_valid1) l1 = k;
            if (l8 < 0 && out_valid8) l8 = k;
        end
        ref_model(la, lb, lbin, ed, ebo, eof);
        chk({tag, "_lat1"}, 64'(l1), 64'd32);
        chk({tag, "_lat8"}, 64'(l8), 64'd4);
        chk({tag, "_diff1"}, 64'(diff1), 64'(ed));
        chk({tag, "_bout1"}, 64'(bout1), 64'(ebo));
        chk({tag, "_of1"}, 64'(of1), 64'(eof));
        chk({tag, "_diff8"}, 64'(diff8), 64'(ed));
        chk({tag, "_bout8"}, 64'(bout8), 64'(ebo));
        chk({tag, "_of8"}, 64'(of8), 64'(eof));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("consume_valid1", 64'(out_valid1), 64'd0);
        chk("consume_valid8", 64'(out_valid8), 64'd0);
        chk("consume_ready1", 64'(in_ready1), 64'd1);
        chk("consume_ready8", 64'(in_ready8), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready1"}, 64'(in_ready1), 64'd1);
        chk({tag, "_valid1"}, 64'(out_valid1), 64'd0);
        chk({tag, "_outs1"}, {30'd0, diff1, bout1, of1}, 64'd0);
        chk({tag, "_ready8"}, 64'(in_ready8), 64'd1);
        chk({tag, "_valid8"}, 64'(out_valid8), 64'd0);
        chk({tag, "_outs8"}, {30'd0, diff8, bout8, of8}, 64'd0);
    endtask

    task automatic full_op(input string tag, input logic [31:0] la, input logic [31:0] lb,
                           input logic lbin);
        launch(la, lb, lbin);
        await_result(tag, la, lb, lbin);
        consume();
    endtask

    initial begin
        logic [31:0] hd1;
        logic [31:0] hd8;
        logic [1:0]  hf1;
        logic [1:0]  hf8;
        logic [31:0] ra;
        logic [31:0] rb;

        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");

        full_op("basic", 32'h0000_0005, 32'h0000_0003, 1'b0);
        full_op("neg_of", 32'h8000_0000, 32'h0000_0001, 1'b0);
        full_op("pos_of", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        full_op("bin_wrap", 32'h0000_0000, 32'h0000_0000, 1'b1);

        // Hold the consumer off while start pulses; nothing may move
        launch(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        await_result("bp_first", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        hd1 = diff1;
        hd8 = diff8;
        hf1 = {bout1, of1};
        hf8 = {bout8, of8};
        for (int i = 0; i < 5; i++) begin
            start = ~start;
            a     = $urandom;
            b     = $urandom;
            @(posedge clk);
            #1;
            chk("bp_valid1", 64'(out_valid1), 64'd1);
            chk("bp_valid8", 64'(out_valid8), 64'd1);
            chk("bp_ready1", 64'(in_ready1), 64'd0);
            chk("bp_ready8", 64'(in_ready8), 64'd0);
            chk("bp_hold1", {30'd0, diff1, bout1, of1}, {30'd0, hd1, hf1});
            chk("bp_hold8", {30'd0, diff8, bout8, of8}, {30'd0, hd8, hf8});
        end
        start = 1'b0;
`ifdef SERIAL_SUB_BACK_TO_BACK_EN
        a         = 32'h0000_0100;
        b         = 32'h0000_0200;
        bin       = 1'b0;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid1", 64'(out_valid1), 64'd0);
        chk("b2b_ready1", 64'(in_ready1), 64'd0);
        await_result("b2b_second", 32'h0000_0100, 32'h0000_0200, 1'b0);
`endif
        consume();

        // Reset and start together: reset wins
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'h1;
        b     = 32'h2;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_start");

        // Reset ten cycles into RUN after a result has been latched
        launch(32'h1111_1111, 32'h2222_2222, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("rst_mid_run");
        full_op("after_rst", 32'h1234_5678, 32'h0234_5670, 1'b1);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = ra;
            if (i % 4 == 1) rb = {~ra[31], rb[30:0]};
            full_op("rand", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
